// File: rtl/spi_cmd_pkg.sv
// Shared opcode, FSM state and packet-length definitions for the SPI command decoder.
package spi_cmd_pkg;

  typedef enum logic [3:0] {
    OP_VERT     = 4'd1,
    OP_TRI      = 4'd2,
    OP_INST_NEW = 4'd3,
    OP_INST_UPD = 4'd4,
    OP_COMMIT   = 4'd15
  } opcode_e;

  typedef enum logic [3:0] {
    StIdle,
    StOpc,
    StVhdr,
    StThdr,
    StInst,
    StVdata,
    StTdata,
    StDone,
    StDiscard
  } state_e;

  // Byte lengths of each packet field.
  localparam logic [5:0] VHDR_B = 6'd5;
  localparam logic [5:0] VTX_B  = 6'd14;
  localparam logic [5:0] TRI_B  = 6'd5;
  localparam logic [5:0] INST_B = 6'd51;

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Byte-stream input and raster-memory strobe outputs of the SPI command decoder.
interface spi_cmd_decoder_if #(
  parameter int unsigned MAX_VERT = 8192,
  parameter int unsigned MAX_TRI  = 8192,
  parameter int unsigned VIDX_W   = 12,
  parameter int unsigned TIDX_W   = 12,
  parameter int unsigned VTX_W    = 108,
  parameter int unsigned TRI_W    = 36,
  parameter int unsigned ID_W     = 8,
  parameter int unsigned TRANS_W  = 384
);
  localparam int unsigned VB_W = $clog2(MAX_VERT);
  localparam int unsigned TB_W = $clog2(MAX_TRI);

  logic               cs_n;
  logic               byte_valid;
  logic [7:0]         byte_in;
  logic               opcode_valid;
  logic [3:0]         opcode;
  logic               vert_hdr_valid;
  logic [ID_W-1:0]    vert_id_out;
  logic [VB_W-1:0]    vert_base;
  logic [VIDX_W-1:0]  vert_count;
  logic               vert_valid;
  logic [VTX_W-1:0]   vert_in;
  logic               tri_hdr_valid;
  logic [ID_W-1:0]    tri_id_out;
  logic [TB_W-1:0]    tri_base;
  logic [TIDX_W-1:0]  tri_count;
  logic               tri_valid;
  logic [TRI_W-1:0]   tri_in;
  logic               inst_valid;
  logic [ID_W-1:0]    inst_id_out;
  logic [TRANS_W-1:0] transform_in;
  logic               create_done;
  logic               proto_err;

  modport master (
    output cs_n, byte_valid, byte_in,
    input  opcode_valid, opcode, vert_hdr_valid, vert_id_out, vert_base, vert_count,
    input  vert_valid, vert_in, tri_hdr_valid, tri_id_out, tri_base, tri_count,
    input  tri_valid, tri_in, inst_valid, inst_id_out, transform_in, create_done, proto_err
  );

  modport slave (
    input  cs_n, byte_valid, byte_in,
    output opcode_valid, opcode, vert_hdr_valid, vert_id_out, vert_base, vert_count,
    output vert_valid, vert_in, tri_hdr_valid, tri_id_out, tri_base, tri_count,
    output tri_valid, tri_in, inst_valid, inst_id_out, transform_in, create_done, proto_err
  );

endinterface

// File: rtl/byte_accum.sv
// Left-shifting byte accumulator with a byte counter; full_o flags the byte that completes
// a field of len_i bytes, and data_o already contains that byte in the same cycle.
module byte_accum #(
  parameter int unsigned W = 384
) (
  input  logic         clk,
  input  logic         rst_sck,
  input  logic         clr_i,
  input  logic         shift_i,
  input  logic [7:0]   byte_i,
  input  logic [5:0]   len_i,
  output logic [W-1:0] data_o,
  output logic [5:0]   cnt_o,
  output logic         full_o
);

  logic [W-1:0] data_q, data_d;
  logic [5:0]   cnt_q, cnt_d;
  logic         unused_msb;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    full_o = 1'b0;
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (shift_i) begin
      data_d = {data_q[W-9:0], byte_i};
      if (cnt_q == len_i - 6'd1) begin
        full_o = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  assign data_o     = data_d;
  assign cnt_o      = cnt_q;
  assign unused_msb = ^data_q[W-1 -: 8];

  always_ff @(posedge clk or posedge rst_sck) begin
    if (rst_sck) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes framed SPI command bytes into opcode, header, vertex, triangle and instance strobes
// for the raster memory; tracks the create_done level and a sticky protocol error.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int unsigned MAX_VERT = 8192,
  parameter int unsigned MAX_TRI  = 8192,
  parameter int unsigned VIDX_W   = 12,
  parameter int unsigned TIDX_W   = 12,
  parameter int unsigned VTX_W    = 108,
  parameter int unsigned TRI_W    = 36,
  parameter int unsigned ID_W     = 8,
  parameter int unsigned TRANS_W  = 384
) (
  input logic             clk,
  input logic             rst_sck,
  spi_cmd_decoder_if.slave bus
);

  localparam int unsigned VB_W  = $clog2(MAX_VERT);
  localparam int unsigned TB_W  = $clog2(MAX_TRI);
  localparam int unsigned CNT_W = (VIDX_W > TIDX_W) ? VIDX_W : TIDX_W;

  state_e             state_q, state_d;
  logic               opcode_valid_q, opcode_valid_d;
  logic [3:0]         opcode_q, opcode_d;
  logic               vert_hdr_valid_q, vert_hdr_valid_d;
  logic [ID_W-1:0]    vert_id_q, vert_id_d;
  logic [VB_W-1:0]    vert_base_q, vert_base_d;
  logic [VIDX_W-1:0]  vert_count_q, vert_count_d;
  logic               vert_valid_q, vert_valid_d;
  logic [VTX_W-1:0]   vert_in_q, vert_in_d;
  logic               tri_hdr_valid_q, tri_hdr_valid_d;
  logic [ID_W-1:0]    tri_id_q, tri_id_d;
  logic [TB_W-1:0]    tri_base_q, tri_base_d;
  logic [TIDX_W-1:0]  tri_count_q, tri_count_d;
  logic               tri_valid_q, tri_valid_d;
  logic [TRI_W-1:0]   tri_in_q, tri_in_d;
  logic               inst_valid_q, inst_valid_d;
  logic [ID_W-1:0]    inst_id_q, inst_id_d;
  logic [TRANS_W-1:0] transform_q, transform_d;
  logic               create_done_q, create_done_d;
  logic               proto_err_q, proto_err_d;
  logic [CNT_W-1:0]   ecnt_q, ecnt_d;
  logic [ID_W-1:0]    inst_tmp_q, inst_tmp_d, vid_tmp_q, vid_tmp_d, tid_tmp_q, tid_tmp_d;

  logic               byte_ok, abort, acc_clr, acc_full;
  logic [5:0]         acc_len, acc_cnt;
  logic [TRANS_W-1:0] acc_data;
  logic [CNT_W-1:0]   ecnt_nxt;

  // A raised chip select wins over a byte arriving in the same cycle.
  assign byte_ok  = bus.byte_valid && !bus.cs_n;
  assign abort    = bus.cs_n && (state_q != StIdle);
  assign ecnt_nxt = ecnt_q + 1'b1;

  byte_accum #(
    .W(TRANS_W)
  ) u_accum (
    .clk     (clk),
    .rst_sck (rst_sck),
    .clr_i   (acc_clr),
    .shift_i (byte_ok),
    .byte_i  (bus.byte_in),
    .len_i   (acc_len),
    .data_o  (acc_data),
    .cnt_o   (acc_cnt),
    .full_o  (acc_full)
  );

  always_comb begin
    state_d          = state_q;
    opcode_valid_d   = 1'b0;
    opcode_d         = opcode_q;
    vert_hdr_valid_d = 1'b0;
    vert_id_d        = vert_id_q;
    vert_base_d      = vert_base_q;
    vert_count_d     = vert_count_q;
    vert_valid_d     = 1'b0;
    vert_in_d        = vert_in_q;
    tri_hdr_valid_d  = 1'b0;
    tri_id_d         = tri_id_q;
    tri_base_d       = tri_base_q;
    tri_count_d      = tri_count_q;
    tri_valid_d      = 1'b0;
    tri_in_d         = tri_in_q;
    inst_valid_d     = 1'b0;
    inst_id_d        = inst_id_q;
    transform_d      = transform_q;
    create_done_d    = create_done_q;
    proto_err_d      = proto_err_q;
    ecnt_d           = ecnt_q;
    inst_tmp_d       = inst_tmp_q;
    vid_tmp_d        = vid_tmp_q;
    tid_tmp_d        = tid_tmp_q;
    acc_clr          = 1'b1;
    acc_len          = VHDR_B;

    if (abort) begin
      state_d = StIdle;
      ecnt_d  = '0;
      if (state_q != StDone && state_q != StDiscard) proto_err_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StOpc: begin
          if (!bus.cs_n) state_d = StOpc;
          if (byte_ok) begin
            opcode_valid_d = 1'b1;
            opcode_d       = bus.byte_in[3:0];
            case (bus.byte_in[3:0])
              OP_VERT:     begin state_d = StVhdr; create_done_d = 1'b0; end
              OP_TRI:      begin state_d = StThdr; create_done_d = 1'b0; end
              OP_INST_NEW: begin state_d = StInst; create_done_d = 1'b0; end
              OP_INST_UPD: state_d = StInst;
              OP_COMMIT:   begin state_d = StDone; create_done_d = 1'b1; end
              default: begin
                opcode_valid_d = 1'b0;
                opcode_d       = opcode_q;
                proto_err_d    = 1'b1;
                state_d        = StDiscard;
              end
            endcase
          end
        end
        StVhdr: begin
          acc_clr = 1'b0;
          if (acc_full) begin
            vert_hdr_valid_d = 1'b1;
            vert_id_d        = acc_data[32 +: ID_W];
            vert_base_d      = acc_data[16 +: VB_W];
            vert_count_d     = acc_data[VIDX_W-1:0];
            ecnt_d           = '0;
            state_d          = (acc_data[VIDX_W-1:0] == '0) ? StDone : StVdata;
          end
        end
        StThdr: begin
          acc_clr = 1'b0;
          if (acc_full) begin
            tri_hdr_valid_d = 1'b1;
            tri_id_d        = acc_data[32 +: ID_W];
            tri_base_d      = acc_data[16 +: TB_W];
            tri_count_d     = acc_data[TIDX_W-1:0];
            ecnt_d          = '0;
            state_d         = (acc_data[TIDX_W-1:0] == '0) ? StDone : StTdata;
          end
        end
        StInst: begin
          acc_clr = 1'b0;
          acc_len = INST_B;
          // The three id bytes fall off the top of the accumulator, so keep them aside.
          if (byte_ok && acc_cnt == 6'd0) inst_tmp_d = bus.byte_in;
          if (byte_ok && acc_cnt == 6'd1) vid_tmp_d = bus.byte_in;
          if (byte_ok && acc_cnt == 6'd2) tid_tmp_d = bus.byte_in;
          if (acc_full) begin
            inst_valid_d = 1'b1;
            inst_id_d    = inst_tmp_q;
            vert_id_d    = vid_tmp_q;
            tri_id_d     = tid_tmp_q;
            transform_d  = acc_data;
            state_d      = StDone;
          end
        end
        StVdata: begin
          acc_clr = 1'b0;
          acc_len = VTX_B;
          if (acc_full) begin
            vert_valid_d = 1'b1;
            vert_in_d    = acc_data[VTX_W-1:0];
            ecnt_d       = ecnt_nxt;
            if (ecnt_nxt == CNT_W'(vert_count_q)) state_d = StDone;
          end
        end
        StTdata: begin
          acc_clr = 1'b0;
          acc_len = TRI_B;
          if (acc_full) begin
            tri_valid_d = 1'b1;
            tri_in_d    = acc_data[TRI_W-1:0];
            ecnt_d      = ecnt_nxt;
            if (ecnt_nxt == CNT_W'(tri_count_q)) state_d = StDone;
          end
        end
        StDone: begin
          if (byte_ok) begin
            proto_err_d = 1'b1;
            state_d     = StDiscard;
          end
        end
        StDiscard: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_sck) begin
    if (rst_sck) begin
      state_q          <= StIdle;
      opcode_valid_q   <= 1'b0;
      opcode_q         <= '0;
      vert_hdr_valid_q <= 1'b0;
      vert_id_q        <= '0;
      vert_base_q      <= '0;
      vert_count_q     <= '0;
      vert_valid_q     <= 1'b0;
      vert_in_q        <= '0;
      tri_hdr_valid_q  <= 1'b0;
      tri_id_q         <= '0;
      tri_base_q       <= '0;
      tri_count_q      <= '0;
      tri_valid_q      <= 1'b0;
      tri_in_q         <= '0;
      inst_valid_q     <= 1'b0;
      inst_id_q        <= '0;
      transform_q      <= '0;
      create_done_q    <= 1'b0;
      proto_err_q      <= 1'b0;
      ecnt_q           <= '0;
      inst_tmp_q       <= '0;
      vid_tmp_q        <= '0;
      tid_tmp_q        <= '0;
    end else begin
      state_q          <= state_d;
      opcode_valid_q   <= opcode_valid_d;
      opcode_q         <= opcode_d;
      vert_hdr_valid_q <= vert_hdr_valid_d;
      vert_id_q        <= vert_id_d;
      vert_base_q      <= vert_base_d;
      vert_count_q     <= vert_count_d;
      vert_valid_q     <= vert_valid_d;
      vert_in_q        <= vert_in_d;
      tri_hdr_valid_q  <= tri_hdr_valid_d;
      tri_id_q         <= tri_id_d;
      tri_base_q       <= tri_base_d;
      tri_count_q      <= tri_count_d;
      tri_valid_q      <= tri_valid_d;
      tri_in_q         <= tri_in_d;
      inst_valid_q     <= inst_valid_d;
      inst_id_q        <= inst_id_d;
      transform_q      <= transform_d;
      create_done_q    <= create_done_d;
      proto_err_q      <= proto_err_d;
      ecnt_q           <= ecnt_d;
      inst_tmp_q       <= inst_tmp_d;
      vid_tmp_q        <= vid_tmp_d;
      tid_tmp_q        <= tid_tmp_d;
    end
  end

  assign bus.opcode_valid   = opcode_valid_q;
  assign bus.opcode         = opcode_q;
  assign bus.vert_hdr_valid = vert_hdr_valid_q;
  assign bus.vert_id_out    = vert_id_q;
  assign bus.vert_base      = vert_base_q;
  assign bus.vert_count     = vert_count_q;
  assign bus.vert_valid     = vert_valid_q;
  assign bus.vert_in        = vert_in_q;
  assign bus.tri_hdr_valid  = tri_hdr_valid_q;
  assign bus.tri_id_out     = tri_id_q;
  assign bus.tri_base       = tri_base_q;
  assign bus.tri_count      = tri_count_q;
  assign bus.tri_valid      = tri_valid_q;
  assign bus.tri_in         = tri_in_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst_id_out    = inst_id_q;
  assign bus.transform_in   = transform_q;
  assign bus.create_done    = create_done_q;
  assign bus.proto_err      = proto_err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: packets are driven byte by byte and the
// resulting strobes and held fields are checked against hand-computed values.
module tb_spi_cmd_decoder;

  logic clk = 1'b0;
  logic rst_sck = 1'b1;
  always #5 clk = ~clk;

  spi_cmd_decoder_if bus ();

  spi_cmd_decoder dut (
    .clk     (clk),
    .rst_sck (rst_sck),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_op = 0, n_vh = 0, n_v = 0, n_th = 0, n_t = 0, n_i = 0, n_all = 0;
  logic [107:0] vpay [4];

  // Pulse counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.opcode_valid)   n_op++;
    if (bus.vert_hdr_valid) n_vh++;
    if (bus.tri_hdr_valid)  n_th++;
    if (bus.tri_valid)      n_t++;
    if (bus.inst_valid)     n_i++;
    if (bus.vert_valid) begin
      vpay[n_v[1:0]] = bus.vert_in;
      n_v++;
    end
    if (bus.opcode_valid || bus.vert_hdr_valid || bus.vert_valid || bus.tri_hdr_valid ||
        bus.tri_valid || bus.inst_valid) n_all++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
    end
  endtask

  task automatic cs_lo();
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.cs_n       = 1'b0;
  endtask

  task automatic cs_hi();
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.cs_n       = 1'b1;
    idle(2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_sck        = 1'b1;
    bus.byte_valid = 1'b0;
    bus.cs_n       = 1'b1;
    idle(2);
    rst_sck = 1'b0;
    idle(1);
  endtask

  int snap_v, snap_t, snap_all;

  initial begin
    bus.cs_n       = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    idle(3);
    chk("rst_opcode_valid", 384'(bus.opcode_valid), 384'(0));
    chk("rst_opcode",       384'(bus.opcode), 384'(0));
    chk("rst_create_done",  384'(bus.create_done), 384'(0));
    chk("rst_proto_err",    384'(bus.proto_err), 384'(0));
    chk("rst_vert_base",    384'(bus.vert_base), 384'(0));
    chk("rst_transform",    bus.transform_in, 384'(0));
    rst_sck = 1'b0;
    idle(2);

    // Vertex buffer: id 5, base 0x100, two vertices.
    cs_lo();
    put(8'h01); put(8'h05); put(8'h01); put(8'h00); put(8'h00); put(8'h02);
    for (int k = 0; k < 14; k++) put((k == 0) ? 8'hF1 : 8'(k + 1));
    for (int k = 0; k < 14; k++) put((k == 0) ? 8'h5F : 8'(8'h20 + k));
    cs_hi();
    chk("vb_opcode_cnt", 384'(n_op), 384'(1));
    chk("vb_opcode",     384'(bus.opcode), 384'(1));
    chk("vb_hdr_cnt",    384'(n_vh), 384'(1));
    chk("vb_id",         384'(bus.vert_id_out), 384'(5));
    chk("vb_base",       384'(bus.vert_base), 384'(13'h100));
    chk("vb_count",      384'(bus.vert_count), 384'(2));
    chk("vb_vert_cnt",   384'(n_v), 384'(2));
    chk("vb_vtx0",       384'(vpay[0]), 384'(108'h1_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E));
    chk("vb_vtx1",       384'(vpay[1]), 384'(108'hF_21_22_23_24_25_26_27_28_29_2A_2B_2C_2D));
    chk("vb_proto_err",  384'(bus.proto_err), 384'(0));

    // Triangle buffer with zero count; a further byte proves the FSM sits in DONE.
    cs_lo();
    put(8'h02); put(8'h07); put(8'h00); put(8'h10); put(8'h00); put(8'h00);
    idle(2);
    chk("tb0_hdr_cnt",   384'(n_th), 384'(1));
    chk("tb0_id",        384'(bus.tri_id_out), 384'(7));
    chk("tb0_base",      384'(bus.tri_base), 384'(13'h010));
    chk("tb0_count",     384'(bus.tri_count), 384'(0));
    chk("tb0_tri_cnt",   384'(n_t), 384'(0));
    chk("tb0_err_clean", 384'(bus.proto_err), 384'(0));
    put(8'h55);
    idle(2);
    chk("tb0_done_byte_err", 384'(bus.proto_err), 384'(1));
    cs_hi();
    do_reset();

    // Instance, commit, then a vertex packet clearing create_done.
    cs_lo();
    put(8'h03); put(8'h09); put(8'h05); put(8'h07);
    for (int k = 0; k < 48; k++) put(8'(k + 1));
    cs_hi();
    chk("in_cnt",     384'(n_i), 384'(1));
    chk("in_inst_id", 384'(bus.inst_id_out), 384'(9));
    chk("in_vert_id", 384'(bus.vert_id_out), 384'(5));
    chk("in_tri_id",  384'(bus.tri_id_out), 384'(7));
    chk("in_transform", bus.transform_in,
        384'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F202122232425262728292A2B2C2D2E2F30);
    chk("in_create_done", 384'(bus.create_done), 384'(0));
    cs_lo();
    put(8'h0F);
    cs_hi();
    chk("cm_create_done", 384'(bus.create_done), 384'(1));
    chk("cm_opcode",      384'(bus.opcode), 384'(15));
    cs_lo();
    put(8'h01); put(8'h03); put(8'h00); put(8'h00); put(8'h00); put(8'h00);
    cs_hi();
    chk("v0_create_done", 384'(bus.create_done), 384'(0));
    chk("v0_id",          384'(bus.vert_id_out), 384'(3));
    chk("v0_count",       384'(bus.vert_count), 384'(0));
    chk("v0_proto_err",   384'(bus.proto_err), 384'(0));

    // Abort after 9 of 14 bytes of the first vertex, then a clean triangle packet.
    snap_v = n_v;
    snap_t = n_t;
    cs_lo();
    put(8'h01); put(8'h05); put(8'h01); put(8'h00); put(8'h00); put(8'h02);
    for (int k = 0; k < 9; k++) put(8'(8'h40 + k));
    cs_hi();
    chk("ab_no_vert", 384'(n_v - snap_v), 384'(0));
    chk("ab_err",     384'(bus.proto_err), 384'(1));
    cs_lo();
    put(8'h02); put(8'h08); put(8'h00); put(8'h20); put(8'h00); put(8'h01);
    put(8'h1A); put(8'hBC); put(8'hDE); put(8'hF0); put(8'h12);
    cs_hi();
    chk("ab_tri_cnt",   384'(n_t - snap_t), 384'(1));
    chk("ab_tri_in",    384'(bus.tri_in), 384'(36'hABCDEF012));
    chk("ab_tri_id",    384'(bus.tri_id_out), 384'(8));
    chk("ab_tri_base",  384'(bus.tri_base), 384'(13'h020));
    chk("ab_tri_count", 384'(bus.tri_count), 384'(1));

    // Unknown opcode 6.
    do_reset();
    snap_all = n_all;
    cs_lo();
    put(8'h06); put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    cs_hi();
    chk("un_no_strobes", 384'(n_all - snap_all), 384'(0));
    chk("un_err",        384'(bus.proto_err), 384'(1));
    chk("un_opcode",     384'(bus.opcode), 384'(0));

    // Back-to-back bytes with reset asserted part way through the transform.
    do_reset();
    cs_lo();
    put(8'h03); put(8'h01); put(8'h02); put(8'h03);
    for (int k = 0; k < 20; k++) put(8'(8'h80 + k));
    @(negedge clk);
    rst_sck     = 1'b1;
    bus.cs_n    = 1'b1;
    bus.byte_in = 8'h77;
    #2;
    chk("rs_inst_valid",  384'(bus.inst_valid), 384'(0));
    chk("rs_opcode",      384'(bus.opcode), 384'(0));
    chk("rs_vert_id",     384'(bus.vert_id_out), 384'(0));
    chk("rs_proto_err",   384'(bus.proto_err), 384'(0));
    chk("rs_create_done", 384'(bus.create_done), 384'(0));
    chk("rs_transform",   bus.transform_in, 384'(0));
    snap_all = n_all;
    @(negedge clk);
    rst_sck = 1'b0;
    for (int k = 0; k < 5; k++) put(8'(8'h90 + k));
    idle(3);
    chk("rs_no_strobe_after", 384'(n_all - snap_all), 384'(0));
    chk("rs_err_after",       384'(bus.proto_err), 384'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Byte-level command decoder between the SPI slave shift register and the raster memory write port. Consumes a framed byte stream (one byte per `byte_valid` strobe, framed by `cs_n`) and emits the opcode, header, vertex, triangle and instance strobes that the raster memory consumes. Also drives the `create_done` level that opens the frame for the raster side.

## Interface
Parameters:
- `MAX_VERT`, 8192: vertex RAM depth; base field width is `$clog2(MAX_VERT)` = 13.
- `MAX_TRI`, 8192: triangle RAM depth; base field width = 13.
- `VIDX_W`, 12: vertex count width.
- `TIDX_W`, 12: triangle count width.
- `VTX_W`, 108: vertex payload width.
- `TRI_W`, 36: triangle payload width (3×12).
- `ID_W`, 8: buffer/instance id width.
- `TRANS_W`, 384: transform width (12×32).

Ports:
- `clk`  in  1  system clock.
- `rst_sck`  in  1  reset, asynchronous, active-high.
- `cs_n`  in  1  SPI chip select, active-low, already synchronized to `clk`.
- `byte_valid`  in  1  one-cycle strobe: `byte_in` is a complete received byte.
- `byte_in`  in  8  received byte, MSB-first order on the wire.
- `opcode_valid` / `opcode`  out  1 / 4  opcode strobe and value.
- `vert_hdr_valid`  out  1  vertex-buffer header strobe.
- `vert_id_out` / `vert_base` / `vert_count`  out  8 / 13 / 12  vertex header fields.
- `vert_valid` / `vert_in`  out  1 / 108  vertex strobe and data.
- `tri_hdr_valid`  out  1  triangle-buffer header strobe.
- `tri_id_out` / `tri_base` / `tri_count`  out  8 / 13 / 12  triangle header fields.
- `tri_valid` / `tri_in`  out  1 / 36  triangle strobe and data.
- `inst_valid` / `inst_id_out` / `transform_in`  out  1 / 8 / 384  instance strobe, instance id, transform.
- `create_done`  out  1  level: scene committed.
- `proto_err`  out  1  sticky protocol error.

## Operation
- Packet = first byte after `cs_n` falls. Byte 0 `[3:0]` is the opcode; `[7:4]` are ignored.
- Opcode 1 (create vertex buffer): header is id(1), base(2), count(2), big-endian, upper unused bits ignored. It is followed by `count` vertices of 14 bytes each; the top 4 bits of the first byte are dropped.
- Opcode 2 (create triangle buffer): header has the same layout as opcode 1. It is followed by `count` triangles of 5 bytes each; the top 4 bits are dropped.
- Opcodes 3/4 (create/update instance): inst id(1), vert id(1), tri id(1), then 48 transform bytes, big-endian. `vert_id_out`/`tri_id_out` carry the vert/tri ids.
- Opcode 15 (commit): sets `create_done`=1. Opcodes 1–3 clear it. Opcode 4 leaves it unchanged.
- Any other opcode: `proto_err`=1, go to DISCARD.
- FSM states: IDLE → OPC → {VHDR, THDR, INST} → {VDATA, TDATA} → DONE. DISCARD is a separate state.
  - IDLE waits for `cs_n`=0. The first `byte_valid` is decoded in OPC.
  - Headers use a byte counter `bcnt` (6 bit) and a 384-bit left-shift accumulator (shift by 8 per byte).
  - VDATA/TDATA use an element counter compared against the latched count.
  - After the last element, or right after the header if count=0, go to DONE.
  - Bytes arriving in DONE set `proto_err` and enter DISCARD.
- `cs_n` rising in any state returns to IDLE next cycle and clears `bcnt` and the counters.
  - If the state was not IDLE/DONE/DISCARD (packet truncated), set `proto_err`.
  - Partial elements are never strobed.
- Output fields hold their value until the next strobe of the same kind.

## Timing
- Every `*_valid` output is a registered one-cycle pulse, asserted the cycle after the `byte_valid` that completes the field. Latency is 1 clk.
- `byte_valid` may arrive every cycle. The decoder never stalls, and it does not backpressure the SPI slave.
- Simultaneous `cs_n` rise and `byte_valid`: the byte is dropped and the abort takes priority.
- Reset values: all strobes 0, all fields 0, `create_done`=0, `proto_err`=0, state IDLE.
- Reset mid-packet discards all state. No strobe is emitted in the cycle after reset release.

## Structure
- `spi_cmd_pkg` holds:
  - the opcode enum (`OP_VERT`=1, `OP_TRI`=2, `OP_INST_NEW`=3, `OP_INST_UPD`=4, `OP_COMMIT`=15);
  - the byte-length constants (`VHDR_B`=5, `VTX_B`=14, `TRI_B`=5, `INST_B`=51).
- One sub-module, `byte_accum`: a shift register with a byte counter and a `full` flag at a programmable length. The decoder FSM instantiates it once.

## Test plan
- Vertex buffer: `cs_n`↓, bytes 01, 05, 01 00, 00 02, then 2×14 bytes, `cs_n`↑ → `opcode_valid` with opcode=1; `vert_hdr_valid` with id=5, base=0x100, count=2; two `vert_valid` pulses carrying the exact 108-bit payloads; `proto_err`=0.
- Triangle buffer with count=0: bytes 02, 07, 00 10, 00 00 → `tri_hdr_valid` with id=7, base=0x10, count=0; no `tri_valid`; state DONE.
- Instance then commit: opcode 3 packet (inst 9, vert 5, tri 7, transform 0x01..0x30) → one `inst_valid` with exactly those fields. Next packet `0F` → `create_done`=1. Next opcode-1 packet → `create_done`=0.
- Abort: `cs_n`↑ after 9 of 14 bytes of vertex 0 → no `vert_valid`, `proto_err`=1, IDLE next cycle. A following valid packet decodes correctly.
- Unknown opcode 0x06 followed by 4 bytes → no strobes, `proto_err`=1.
- Back-to-back `byte_valid` every cycle, plus async reset asserted mid-transform → all outputs at reset values, and no `inst_valid` after release.
